// File: rtl/arccos_unit.sv
// Fixed-point arccos: s = 1 - C^2, r = sqrt(s), then CORDIC vectoring
// of (C, r) gives atan2(r, C) as an unsigned Q6.10 angle.
module arccos_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10,
    parameter int GUARD = 4,
    parameter int ITER  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] C,
    output logic                    done,
    output logic [WIDTH-1:0]        AcosX,
    output logic                    err
);

    localparam int DW = WIDTH + GUARD + 2;
    localparam int RW = FRAC + 1;
    localparam int SW = 2 * RW;
    localparam int MW = RW + 4;
    localparam int CW = 5;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQ   = 3'd1;
    localparam logic [2:0] SQRT = 3'd2;
    localparam logic [2:0] PRE  = 3'd3;
    localparam logic [2:0] ROT  = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;
    localparam logic [2:0] HOLD = 3'd6;

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);
    localparam logic [SW-1:0] ONE_SQ = SW'(1) << (2 * FRAC);
    localparam logic signed [DW-1:0] HALFPI = DW'(25736);
    localparam logic signed [DW-1:0] ZRND = DW'(1 << (GUARD - 1));
    localparam logic signed [DW-1:0] ZMAX = DW'(3217);

    logic [2:0]              state;
    logic signed [WIDTH-1:0] cs;
    logic                    errf;
    logic [SW-1:0]           sop;
    logic [MW-1:0]           rem;
    logic [RW-1:0]           root;
    logic [CW-1:0]           cnt;
    logic signed [DW-1:0]    x, y, z;

    logic [RW-1:0]        cmag;
    logic [SW-1:0]        sq;
    logic [MW-1:0]        rem_sh, trial;
    logic                 fits;
    logic signed [DW-1:0] x0, y0, xs, ys, tz, zr;

    // atan(2^-i) scaled by 2^(FRAC+GUARD)
    function automatic logic signed [DW-1:0] atan_t(input logic [CW-1:0] i);
        logic signed [DW-1:0] t;
        case (i)
            5'd0:    t = DW'(12868);
            5'd1:    t = DW'(7596);
            5'd2:    t = DW'(4014);
            5'd3:    t = DW'(2037);
            5'd4:    t = DW'(1023);
            5'd5:    t = DW'(512);
            5'd6:    t = DW'(256);
            5'd7:    t = DW'(128);
            5'd8:    t = DW'(64);
            5'd9:    t = DW'(32);
            5'd10:   t = DW'(16);
            5'd11:   t = DW'(8);
            5'd12:   t = DW'(4);
            5'd13:   t = DW'(2);
            5'd14:   t = DW'(1);
            default: t = '0;
        endcase
        return t;
    endfunction

    always_comb begin
        cmag   = cs[WIDTH-1] ? RW'(-cs) : RW'(cs);
        sq     = cmag * cmag;
        rem_sh = (rem << 2) | {{(MW-2){1'b0}}, sop[SW-1:SW-2]};
        trial  = MW'({root, 2'b01});
        fits   = rem_sh >= trial;
        x0     = {{(DW-WIDTH){cs[WIDTH-1]}}, cs} <<< GUARD;
        y0     = {{(DW-RW){1'b0}}, root} << GUARD;
        xs     = x >>> cnt;
        ys     = y >>> cnt;
        tz     = atan_t(cnt);
        zr     = (z + ZRND) >>> GUARD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cs    <= '0;
            errf  <= 1'b0;
            sop   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            done  <= 1'b0;
            AcosX <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        done  <= 1'b0;
                        state <= SQ;
                        if (C > ONE) begin
                            cs   <= ONE;
                            errf <= 1'b1;
                        end else if (C < -ONE) begin
                            cs   <= -ONE;
                            errf <= 1'b1;
                        end else begin
                            cs   <= C;
                            errf <= 1'b0;
                        end
                    end
                end
                SQ: begin
                    sop   <= ONE_SQ - sq;
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= '0;
                    state <= SQRT;
                end
                SQRT: begin
                    sop <= sop << 2;
                    if (fits) begin
                        rem  <= rem_sh - trial;
                        root <= {root[RW-2:0], 1'b1};
                    end else begin
                        rem  <= rem_sh;
                        root <= {root[RW-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(RW - 1)) state <= PRE;
                end
                PRE: begin
                    // second-quadrant vectors are pre-rotated by -pi/2
                    if (cs[WIDTH-1]) begin
                        x <= y0;
                        y <= -x0;
                        z <= HALFPI;
                    end else begin
                        x <= x0;
                        y <= y0;
                        z <= '0;
                    end
                    cnt   <= '0;
                    state <= ROT;
                end
                ROT: begin
                    if (!y[DW-1]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + tz;
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - tz;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FIN;
                end
                FIN: begin
                    if (zr[DW-1])
                        AcosX <= '0;
                    else if (zr > ZMAX)
                        AcosX <= ZMAX[WIDTH-1:0];
                    else
                        AcosX <= zr[WIDTH-1:0];
                    err   <= errf;
                    done  <= 1'b1;
                    state <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arccos_unit.sv
// Bench for arccos_unit: vector table, hand sequences, random and
// round-trip checks against a real-arithmetic arccos reference.
module tb_arccos_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] C;
    logic               done;
    logic [15:0]        AcosX;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arccos_unit dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .C    (C),
        .done (done),
        .AcosX(AcosX),
        .err  (err)
    );

    typedef struct {
        int c;
        int a;
        int e;
    } vec_t;

    function automatic int ref_acos(input int c);
        real r;
        if (c > 1024) r = 1.0;
        else if (c < -1024) r = -1.0;
        else r = c / 1024.0;
        return $rtoi(1024.0 * $acos(r) + 0.5);
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act - exp > tol || exp - act > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // One request; optional extra start pulse or reset at cycle n after accept.
    task automatic run(input int c, input int ign_at, input int c2, input int rst_at,
                       output int lat, output int a, output int e);
        @(negedge clk);
        C = 16'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_clr_on_accept", int'(done), 0, 0);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (n == ign_at) begin
                start = 1'b1;
                C = 16'(c2);
            end else begin
                start = 1'b0;
            end
            if (n == rst_at) rst = 1'b1;
        end
        start = 1'b0;
        a = int'(AcosX);
        e = int'(err);
    endtask

    initial begin
        vec_t tbl[8];
        int lat, a, e, cq, tol;
        real qerr;

        tbl[0] = '{c: 1024,  a: 0,    e: 0};
        tbl[1] = '{c: 0,     a: 1608, e: 0};
        tbl[2] = '{c: -1024, a: 3217, e: 0};
        tbl[3] = '{c: 724,   a: 804,  e: 0};
        tbl[4] = '{c: 512,   a: 1072, e: 0};
        tbl[5] = '{c: 2000,  a: 0,    e: 1};
        tbl[6] = '{c: -3000, a: 3217, e: 1};
        tbl[7] = '{c: -512,  a: 2145, e: 0};

        rst = 1'b1;
        start = 1'b0;
        C = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_done", int'(done), 0, 0);
        chk("reset_acos", int'(AcosX), 0, 0);
        chk("reset_err", int'(err), 0, 0);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].c, 0, 0, 0, lat, a, e);
            chk("tbl_latency", lat, 28, 0);
            chk("tbl_acos", a, tbl[i].a, 3);
            chk("tbl_err", e, tbl[i].e, 0);
        end

        run(-3000, 0, 0, 0, lat, a, e);
        chk("sat_err_set", e, 1, 0);
        run(100, 0, 0, 0, lat, a, e);
        chk("err_clears", e, 0, 0);
        chk("err_clears_acos", a, ref_acos(100), 3);

        run(512, 10, -900, 0, lat, a, e);
        chk("ignored_start_lat", lat, 28, 0);
        chk("ignored_start_acos", a, 1072, 3);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_stable_done", int'(done), 1, 0);
        chk("hold_stable_acos", int'(AcosX), a, 0);

        run(300, 0, 0, 15, lat, a, e);
        chk("abort_no_done", lat, -1, 0);
        chk("abort_done", int'(done), 0, 0);
        chk("abort_acos", int'(AcosX), 0, 0);
        run(-700, 0, 0, 0, lat, a, e);
        chk("after_abort_lat", lat, 28, 0);
        chk("after_abort_acos", a, ref_acos(-700), 3);

        for (int k = 0; k < 40; k++) begin
            int c;
            c = int'($urandom_range(2400, 0)) - 1200;
            run(c, 0, 0, 0, lat, a, e);
            chk("rand_lat", lat, 28, 0);
            chk("rand_acos", a, ref_acos(c), 3);
            chk("rand_err", e, (c > 1024 || c < -1024) ? 1 : 0, 0);
        end

        // Near cos = +-1 a 1-LSB cosine step spans many angle LSBs, so the
        // round-trip window widens by the quantised cosine's own angle error.
        for (int x = 0; x <= 3217; x += 64) begin
            cq = $rtoi($floor(1024.0 * $cos(x / 1024.0) + 0.5));
            qerr = 1024.0 * $acos(cq / 1024.0) - x;
            if (qerr < 0.0) qerr = -qerr;
            tol = 6 + $rtoi($ceil(qerr));
            run(cq, 0, 0, 0, lat, a, e);
            chk("roundtrip", a, x, tol);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arccos_unit.md
Name: arccos_unit

Overview:
- Inverse of the team's 16-bit fixed-point cosine calculator: takes a cosine value C and returns AcosX = arccos(C) in radians.
- Uses the same start/done level handshake and the same Q6.10 signed format (1.0 = 1024) as the cosine block, so the two can be chained for round-trip checking.
- Internally:
  - computes s = 1 − C² and r = sqrt(s) with an iterative restoring square root;
  - then runs CORDIC vectoring on (C, r) to produce atan2(r, C).

Parameters:
- WIDTH, 16, data width of C and AcosX.
- FRAC, 10, fractional bits of the external Q format.
- GUARD, 4, extra fractional bits inside the CORDIC datapath.
- ITER, 14, number of CORDIC vectoring iterations.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or HOLD.
- C  input  WIDTH  signed Q6.10 cosine value, sampled on the start-accept edge.
- done  output  1  result valid; held high until the next accepted start or rst.
- AcosX  output  WIDTH  unsigned Q6.10 angle, range 0..3217.
- err  output  1  input out of range (|C| > 1024); valid while done = 1.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - state → IDLE; done = 0, AcosX = 0, err = 0.
  - All internal registers are cleared.
  - Reset applied mid-operation aborts the computation; no done pulse is produced.
- States and transitions: IDLE → SQ → SQRT → PRE → ROT → FIN → HOLD.
  - From HOLD, start=1 re-enters SQ directly.
  - start is ignored in every state except IDLE and HOLD.
- Start accept (edge 0, state IDLE or HOLD with start = 1):
  - latch C; done → 0 on this same edge.
  - If C > 1024 or C < −1024: saturate the latched value to ±1024 and set the internal err flag.
- SQ (1 cycle): s = 2^20 − Cs². Cs² is computed as a 22-bit unsigned product, so s is unsigned Q.20 with range 0..2^20.
- SQRT (11 cycles): restoring integer square root of s, one result bit per cycle, MSB first. Result r is an 11-bit unsigned Q.10 value, 0..1024, truncated.
- PRE (1 cycle):
  - x = Cs << GUARD, y = r << GUARD. Both are signed, width WIDTH + GUARD + 2.
  - If x < 0: (x, y) ← (y, −x) and z ← round(π/2 · 2^(FRAC+GUARD)). Otherwise z ← 0.
- ROT (ITER cycles), iteration i = 0..ITER−1, one per cycle:
  - If y ≥ 0: x += y>>>i, y −= x>>>i, z += T[i].
  - Otherwise: x −= y>>>i, y += x>>>i, z −= T[i].
  - T[i] = round(atan(2^−i) · 2^(FRAC+GUARD)), held as a constant table.
  - The x and y updates use the pre-update values of x and y.
  - The gain K is irrelevant because only z is used.
- FIN (1 cycle):
  - AcosX ← (z + 2^(GUARD−1)) >> GUARD, clamped to 0..3217.
  - err ← the latched flag; done ← 1.
- HOLD: done, AcosX and err stay stable.
- Latency: done rises on edge 14 + ITER after the accept edge, i.e. edge 28 with defaults.
- Accuracy: |AcosX − round(1024·arccos(C/1024))| ≤ 3 LSB for every in-range C.
- Boundary cases:
  - C = ±1024 gives r = 0.
  - C = 0 takes the x ≥ 0 branch (no pre-rotation).
  - Out-of-range inputs produce the saturated result, e.g. 0 or 3217, together with err = 1.

Test Plan:
- rst for 2 cycles, then C = 1024 with a start pulse → done high exactly 28 cycles after accept; AcosX = 0 ±3, err = 0.
- C = 0 → AcosX = 1608 ±3. C = −1024 → AcosX = 3217 ±3. C = 724 (cos π/4) → AcosX = 804 ±3. C = 512 → AcosX = 1072 ±3.
- C = 2000 → err = 1, AcosX = 0 ±3. Then C = −3000 → err = 1, AcosX = 3217 ±3, and err clears on the next in-range request.
- Pulse start again at cycle 10 of an operation with a different C → ignored: done still rises at cycle 28 with the first result, and the result is unchanged.
- Assert rst at cycle 15 of an operation → done stays 0, AcosX = 0. A new start afterwards completes normally in 28 cycles.
- Round trip: sweep X = 0..3217 step 64, feed each X to the cosine block, feed its CosX into arccos_unit → result within ±6 LSB of X.
